serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each: operands, sampled on the start-accept edge.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, sampled on the start-accept edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that sum/cout were just updated.
REQ-009 The block SHALL have port sum, output, WIDTH bits: registered result, held until the next completion.
REQ-010 The block SHALL have port cout, output, 1 bit: registered carry-out, held with sum.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL, on the edge:
- latch a and b into shift registers;
- load the carry flop with cin;
- clear the bit counter;
- go to RUN.
REQ-013 In RUN, each edge SHALL:
- feed the LSBs of both shift registers plus the carry flop into one fulladder instance;
- shift the sum bit into the result shift register from the MSB side;
- shift both operand registers right by one;
- load the carry flop with the adder's cout;
- increment the counter.
REQ-014 When the counter equals WIDTH-1, the RUN edge SHALL go to DONE and load sum and cout from the completed result.
REQ-015 Latency: done SHALL be high in the cycle beginning exactly WIDTH rising edges after the start-accept edge.
REQ-016 The block SHALL hold done=1 for exactly one cycle in DONE, then return to IDLE on the next edge.
REQ-017 start SHALL be ignored in RUN and DONE; no queuing.
REQ-018 sum and cout SHALL NOT change during RUN; they keep the previous result until the DONE transition.
REQ-019 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within an operation.
REQ-020 Arithmetic SHALL be unsigned modulo 2^WIDTH, with carry out of the MSB reported on cout.

Reset
REQ-021 rst=1 SHALL force on the next edge: state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0.
REQ-022 rst SHALL take priority over start and over any in-progress RUN.
REQ-023 After a mid-operation reset, no done SHALL be generated for the aborted operation.

Configuration
REQ-024 With SERIAL_ADD_OVF_EN defined, the block SHALL add output port ovf (1 bit, reset 0) carrying signed overflow, i.e. carry into the MSB XOR carry out of the MSB.
REQ-025 With SERIAL_ADD_OVF_EN defined, ovf SHALL be registered and updated together with sum.
REQ-026 Without SERIAL_ADD_OVF_EN, the ovf port and its logic SHALL be absent.

Structure
REQ-027 A package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 The block SHALL instantiate exactly one existing fulladder sub-module, with ports a, b, cin, sum, cout, as its only arithmetic; no behavioural '+' on operands.

Verification (WIDTH=8)
REQ-029 Scenario "basic add": a=8'h0F, b=8'h01, cin=0, start pulse -> done after 8 edges, sum=8'h10, cout=0, busy high for 9 cycles.
REQ-030 Scenario "carry out": a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; and a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-031 Scenario "start while busy": second start with a=8'h55 three cycles into RUN -> ignored; exactly one done, result unchanged from the first operation.
REQ-032 Scenario "mid-operation reset": rst asserted at counter=3 -> next cycle all outputs 0, no done; a following start with 8'h02+8'h03 -> sum=8'h05.
REQ-033 Scenario "overflow" (SERIAL_ADD_OVF_EN defined): a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
REQ-034 Scenario "exhaustive small": WIDTH=2, all 32 combinations of {a,b,cin} applied back-to-back -> every result matches a+b+cin.

Source files
------------

// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared state encoding and default operand width for serial_add_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int c_default_width = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fulladder.sv
// ============================================================================
// Module   : fulladder
// Purpose  : One-bit full adder used as the serial adder's only arithmetic cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign sum   = w_axb ^ cin;
  assign cout  = (a & b) | (cin & w_axb);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial unsigned adder, one bit per clock, LSB first.
//            Define SERIAL_ADD_OVF_EN to add a registered signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_res;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_fs;
  logic               w_fc;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  fulladder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fs),
    .cout (w_fc)
  );

  // Partial result keeps WIDTH-1 bits; the final bit joins it on the last edge.
  assign w_res_next = {w_fs, r_res};
  assign w_last     = (r_state == RUN) && (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= (WIDTH-1)'(w_res_next >> 1);
          r_carry <= w_fc;
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_fc;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the last edge r_carry is the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_fc;
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Directed self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=2).
//            Overflow checks are compiled in when SERIAL_ADD_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       cin2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
  logic ovf2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .cin   (cin2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one 8-bit operation for 12 cycles after the start edge, optionally
  // injecting a second start (inj_at) or a reset (rst_at) at a sample index.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_cin,
                        input int inj_at, input int rst_at,
                        output int nbusy, output int ndone, output int done_at,
                        output bit held_ok, output bit rst_zero_ok);
    logic [7:0] prev;
    prev        = sum;
    nbusy       = 0;
    ndone       = 0;
    done_at     = -1;
    held_ok     = 1'b1;
    rst_zero_ok = 1'b1;
    a     = op_a;
    b     = op_b;
    cin   = op_cin;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst = 1'b0;
        if (busy || done || sum != 8'h00 || cout) rst_zero_ok = 1'b0;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
      if (done_at < 0 && rst_at < 0 && sum !== prev) held_ok = 1'b0;
      if (i == inj_at) begin
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h55;
      end
      if (i == rst_at) rst = 1'b1;
    end
  endtask

  int         nb;
  int         nd;
  int         dat;
  bit         hok;
  bit         rok;
  bit         got_done;
  logic [2:0] exp2;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    cin    = 1'b0;
    start2 = 1'b0;
    a2     = 2'b00;
    b2     = 2'b00;
    cin2   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_sum", 32'(sum), 32'h00);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_busy2", 32'(busy2), 32'h0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'h0);
`endif
    rst = 1'b0;

    run_op(8'h0F, 8'h01, 1'b0, -1, -1, nb, nd, dat, hok, rok);
    check("basic_sum", 32'(sum), 32'h10);
    check("basic_cout", 32'(cout), 32'h0);
    check("basic_latency", 32'(dat), 32'd8);
    check("basic_busy_cycles", 32'(nb), 32'd9);
    check("basic_done_count", 32'(nd), 32'd1);
    check("basic_sum_held", 32'(hok), 32'h1);
`ifdef SERIAL_ADD_OVF_EN
    check("basic_ovf", 32'(ovf), 32'h0);
`endif

    run_op(8'hFF, 8'h01, 1'b0, -1, -1, nb, nd, dat, hok, rok);
    check("carry1_sum", 32'(sum), 32'h00);
    check("carry1_cout", 32'(cout), 32'h1);
    check("carry1_sum_held", 32'(hok), 32'h1);

    run_op(8'hFF, 8'hFF, 1'b1, -1, -1, nb, nd, dat, hok, rok);
    check("carry2_sum", 32'(sum), 32'hFF);
    check("carry2_cout", 32'(cout), 32'h1);

    run_op(8'h12, 8'h34, 1'b0, 2, -1, nb, nd, dat, hok, rok);
    check("busy_start_done_count", 32'(nd), 32'd1);
    check("busy_start_latency", 32'(dat), 32'd8);
    check("busy_start_sum", 32'(sum), 32'h46);
    check("busy_start_cout", 32'(cout), 32'h0);
    check("busy_start_sum_held", 32'(hok), 32'h1);

    run_op(8'h20, 8'h21, 1'b0, -1, 3, nb, nd, dat, hok, rok);
    check("midrst_outputs_zero", 32'(rok), 32'h1);
    check("midrst_no_done", 32'(nd), 32'd0);
    check("midrst_sum_after", 32'(sum), 32'h00);

    run_op(8'h02, 8'h03, 1'b0, -1, -1, nb, nd, dat, hok, rok);
    check("postrst_sum", 32'(sum), 32'h05);
    check("postrst_cout", 32'(cout), 32'h0);
    check("postrst_done_count", 32'(nd), 32'd1);

`ifdef SERIAL_ADD_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, -1, -1, nb, nd, dat, hok, rok);
    check("ovf1_sum", 32'(sum), 32'h80);
    check("ovf1_cout", 32'(cout), 32'h0);
    check("ovf1_ovf", 32'(ovf), 32'h1);

    run_op(8'h80, 8'h80, 1'b0, -1, -1, nb, nd, dat, hok, rok);
    check("ovf2_sum", 32'(sum), 32'h00);
    check("ovf2_cout", 32'(cout), 32'h1);
    check("ovf2_ovf", 32'(ovf), 32'h1);
`endif

    // WIDTH=2: every {a,b,cin} combination, each started as soon as the block is idle.
    for (int v = 0; v < 32; v++) begin
      a2       = v[4:3];
      b2       = v[2:1];
      cin2     = v[0];
      exp2     = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
      start2   = 1'b1;
      got_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        start2 = 1'b0;
        if (done2) begin
          got_done = 1'b1;
          break;
        end
      end
      if (!got_done) begin
        check($sformatf("w2_timeout_%0d", v), 32'h0, 32'h1);
      end else begin
        check($sformatf("w2_result_%0d", v), 32'({cout2, sum2}), 32'(exp2));
      end
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
